// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response bundle for mem_access_ctrl.
// The master side issues load/store requests; the slave side is the controller.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: byte/half/word loads and stores over a word-addressed sync RAM.
// Optional MEM_ACCESS_STATS_EN adds saturating load/store/error counters.
module mem_access_ctrl #(
  parameter int MEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_ctrl_if.slave   bus,
  output logic               Mem_WrEn,
  output logic [31:0]        ALU_MEM_Addr,
  output logic [31:0]        MEM_DataIn,
  input  logic [31:0]        MEM_DataOut
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]        stat_loads,
  output logic [15:0]        stat_stores,
  output logic [15:0]        stat_errs
`endif
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept, err_acc;
  logic [1:0]  lane_q, size_q;
  logic        we_q, sgn_q;
  logic [15:0] wdata_q;
  logic [3:0][7:0] rd_lanes, wr_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    err_acc = 1'b0;
    if (bus.req_size == 2'b11)                                  err_acc = 1'b1;
    else if (bus.req_size == 2'b01 && bus.req_addr[0])          err_acc = 1'b1;
    else if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) err_acc = 1'b1;
    else if ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS))     err_acc = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    Mem_WrEn       = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (err_acc)                                  state_nxt = DONE;
          else if (bus.req_we && bus.req_size == 2'b10) state_nxt = WR;
          else                                          state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = we_q ? WR : DONE;
      WR: begin
        Mem_WrEn  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lane merge for sub-word stores and extraction for loads
  assign rd_lanes = MEM_DataOut;
  assign ld_byte  = rd_lanes[lane_q];
  assign ld_half  = {rd_lanes[{lane_q[1], 1'b1}], rd_lanes[{lane_q[1], 1'b0}]};

  always_comb begin
    wr_lanes = rd_lanes;
    if (size_q == 2'b00) begin
      wr_lanes[lane_q] = wdata_q[7:0];
    end else begin
      wr_lanes[{lane_q[1], 1'b0}] = wdata_q[7:0];
      wr_lanes[{lane_q[1], 1'b1}] = wdata_q[15:8];
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   ld_ext = sgn_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      2'b01:   ld_ext = sgn_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: ld_ext = MEM_DataOut;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q         <= '0;
      size_q         <= '0;
      we_q           <= 1'b0;
      sgn_q          <= 1'b0;
      wdata_q        <= '0;
      ALU_MEM_Addr   <= '0;
      MEM_DataIn     <= '0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lane_q  <= bus.req_addr[1:0];
        size_q  <= bus.req_size;
        we_q    <= bus.req_we;
        sgn_q   <= bus.req_signed;
        wdata_q <= bus.req_wdata[15:0];
        // Errored requests leave the memory address untouched
        if (!err_acc) begin
          ALU_MEM_Addr <= {bus.req_addr[31:2], 2'b00};
          MEM_DataIn   <= bus.req_wdata;
        end else begin
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b1;
        end
      end
      if (state == RD_WAIT) begin
        if (we_q) begin
          MEM_DataIn <= wr_lanes;
        end else begin
          bus.resp_rdata <= ld_ext;
          bus.resp_err   <= 1'b0;
        end
      end
      if (state == WR) begin
        bus.resp_rdata <= '0;
        bus.resp_err   <= 1'b0;
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (state == DONE) begin
      if (bus.resp_err) begin
        if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      end else if (we_q) begin
        if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
      end else begin
        if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a word-addressed sync RAM model.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();
  logic        Mem_WrEn;
  logic [31:0] ALU_MEM_Addr, MEM_DataIn, MEM_DataOut;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  mem_access_ctrl #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .Mem_WrEn(Mem_WrEn), .ALU_MEM_Addr(ALU_MEM_Addr),
    .MEM_DataIn(MEM_DataIn), .MEM_DataOut(MEM_DataOut)
`ifdef MEM_ACCESS_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  // RAM model: read data appears the cycle after the address
  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we)        mem[pre_addr] <= pre_data;
    else if (Mem_WrEn) mem[ALU_MEM_Addr[11:2]] <= MEM_DataIn;
    MEM_DataOut <= mem[ALU_MEM_Addr[11:2]];
  end

  int n_chk = 0, n_err = 0;
  int wr_cnt, wr_k, resp_cnt, resp_k, resp_k1, resp_k2;
  logic [31:0] wr_addr, wr_data, rdata, rd1, rd2;
  logic err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wr_cnt = 0; wr_k = 0; resp_cnt = 0; resp_k = 0; resp_k1 = 0; resp_k2 = 0;
    wr_addr = '0; wr_data = '0; rdata = '0; rd1 = '0; rd2 = '0; err = 1'b0;
  endtask

  // Called at a negedge; k is the cycle offset from the accept edge
  task automatic sample(input int k);
    if (Mem_WrEn) begin
      wr_cnt++; wr_k = k; wr_addr = ALU_MEM_Addr; wr_data = MEM_DataIn;
    end
    if (bus.resp_valid) begin
      resp_cnt++; resp_k = k; rdata = bus.resp_rdata; err = bus.resp_err;
      if (resp_cnt == 1) begin resp_k1 = k; rd1 = bus.resp_rdata; end
      else               begin resp_k2 = k; rd2 = bus.resp_rdata; end
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    chk("ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    clr();
  endtask

  task automatic run(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata);
    drive(we, size, sgn, addr, wdata);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask

  task automatic load_chk(input string tag, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] exp);
    run(1'b0, size, sgn, addr, 32'h0);
    chk({tag, "_resp_cycle"}, resp_k, 3);
    chk({tag, "_resp_count"}, resp_cnt, 1);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_no_write"}, wr_cnt, 0);
    chk({tag, "_rdata_held"}, bus.resp_rdata, exp);
  endtask

  task automatic store_chk(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_wk,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
    run(1'b1, size, 1'b0, addr, wdata);
    chk({tag, "_write_count"}, wr_cnt, 1);
    chk({tag, "_write_cycle"}, wr_k, exp_wk);
    chk({tag, "_write_addr"}, wr_addr, exp_addr);
    chk({tag, "_write_data"}, wr_data, exp_data);
    chk({tag, "_resp_cycle"}, resp_k, exp_wk + 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic err_chk(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr);
    run(we, size, 1'b0, addr, 32'hDEADBEEF);
    chk({tag, "_resp_cycle"}, resp_k, 1);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_no_write"}, wr_cnt, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_wren", Mem_WrEn, 0);
    chk("rst_addr", ALU_MEM_Addr, 0);
    chk("rst_datain", MEM_DataIn, 0);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);

    // 1: word store then load back
    store_chk("sw4", 2'b10, 32'd4, 32'h0000001F, 1, 32'd4, 32'h0000001F);
    load_chk("lw4", 2'b10, 1'b0, 32'd4, 32'h0000001F);

    // 2: byte store merge and byte loads
    pre_we = 1'b1; pre_addr = 10'd2; pre_data = 32'h11223344;
    @(posedge clk); #1 pre_we = 1'b0;
    @(negedge clk);
    store_chk("sb9", 2'b00, 32'd9, 32'h000000AB, 3, 32'd8, 32'h1122AB44);
    chk("sb9_mem", mem[2], 32'h1122AB44);
    load_chk("lb9", 2'b00, 1'b1, 32'd9, 32'hFFFFFFAB);
    load_chk("lbu9", 2'b00, 1'b0, 32'd9, 32'h000000AB);

    // 3: halfword store merge and halfword loads
    store_chk("sh8", 2'b01, 32'd8, 32'h00008001, 3, 32'd8, 32'h11228001);
    chk("sh8_mem", mem[2], 32'h11228001);
    load_chk("lh8", 2'b01, 1'b1, 32'd8, 32'hFFFF8001);
    load_chk("lhu10", 2'b01, 1'b0, 32'd10, 32'h00001122);

    // 4: error cases
    err_chk("lw1", 1'b0, 2'b10, 32'd1);
    err_chk("lh3", 1'b0, 2'b01, 32'd3);
    err_chk("size11", 1'b0, 2'b11, 32'd0);
    err_chk("sw4096", 1'b1, 2'b10, 32'd4096);
    chk("err_mem1_intact", mem[1], 32'h0000001F);
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_loads_pre", stat_loads, 5);
    chk("stat_stores_pre", stat_stores, 3);
    chk("stat_errs_pre", stat_errs, 4);
`endif

    // 5: reset during RD_WAIT of a byte store
    drive(1'b1, 2'b00, 1'b0, 32'd9, 32'h000000CD);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 2) reset = 1'b1;
      if (k == 3) reset = 1'b0;
      if (k == 4) chk("abort_ready_after_reset", bus.req_ready, 1);
    end
    chk("abort_no_write", wr_cnt, 0);
    chk("abort_no_resp", resp_cnt, 0);
    chk("abort_mem_intact", mem[2], 32'h11228001);
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_loads_cleared", stat_loads, 0);
`endif

    // 6: back-to-back loads with req_valid held high
    chk("b2b_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'd4;
    @(posedge clk); #1;
    bus.req_addr = 32'd8;
    clr();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sample(k);
      if (k <= 4) chk($sformatf("b2b_ready_k%0d", k), bus.req_ready, (k == 4) ? 1 : 0);
      if (k == 4) begin
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
      end
    end
    chk("b2b_resp_count", resp_cnt, 2);
    chk("b2b_first_cycle", resp_k1, 3);
    chk("b2b_first_rdata", rd1, 32'h0000001F);
    chk("b2b_second_cycle", resp_k2, 7);
    chk("b2b_second_rdata", rd2, 32'h11228001);
    chk("b2b_no_write", wr_cnt, 0);
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_loads", stat_loads, 2);
    chk("stat_stores", stat_stores, 0);
    chk("stat_errs", stat_errs, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the pipeline over a valid/ready handshake and drives the word-addressed synchronous data memory through Mem_WrEn / ALU_MEM_Addr / MEM_DataIn / MEM_DataOut.
- Adds byte and halfword access: extraction and sign/zero extension on loads, read-modify-write on sub-word stores.
- Flags misaligned and out-of-range accesses.
- Sits between the EX/MEM pipeline register and the data memory.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in data memory; word index = addr[31:2], must be < MEM_WORDS

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid; misaligned, illegal size or out of range
Mem_WrEn  output  1  memory write enable
ALU_MEM_Addr  output  32  word-aligned memory address {addr[31:2],2'b00}
MEM_DataIn  output  32  memory write data
MEM_DataOut  input  32  memory read data; valid by the end of the cycle after the address is driven

Behaviour:
- Reset values: state IDLE; req_ready=1 (first cycle after reset released); resp_valid=0; resp_err=0; resp_rdata=0; Mem_WrEn=0; ALU_MEM_Addr=0; MEM_DataIn=0.
- Request accept: on the edge T where req_valid && req_ready. addr, we, size, signed and wdata are latched. req_ready is 0 in every state except IDLE.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, DONE.
- Error check at accept, in priority order:
  - size==11
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - addr[31:2] >= MEM_WORDS
  - Any error: IDLE->DONE with resp_err=1 and resp_rdata=0. No memory access: Mem_WrEn never asserted. resp_valid in cycle T+1.
- Word store: IDLE->WR->DONE. In WR (cycle T+1): Mem_WrEn=1, MEM_DataIn=wdata. resp_valid in T+2.
- Load: IDLE->RD_ISSUE->RD_WAIT->DONE. Address driven from T+1. MEM_DataOut sampled at the end of RD_WAIT. resp_valid with resp_rdata in T+3.
- Sub-word store: IDLE->RD_ISSUE->RD_WAIT->WR->DONE.
  - The captured word is merged; only the target lane is replaced.
  - Write happens in T+3; resp_valid in T+4.
- Lane mapping is little-endian:
  - byte lane = addr[1:0], bits [8*addr[1:0]+7 : 8*addr[1:0]]
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]]
- Load extension: req_signed=1 replicates the lane MSB; 0 fills with zeros. Word loads ignore req_signed.
- Mem_WrEn is high only in WR, exactly one cycle per store. It is 0 in all other states.
- DONE->IDLE unconditionally. resp_valid lasts one cycle. resp_rdata and resp_err are held until the next DONE.
- Reset mid-operation:
  - aborts the operation; state returns to IDLE on the next edge
  - no resp_valid and no Mem_WrEn after the reset edge
  - a sub-word store aborted before WR leaves memory unchanged
- req_valid while not ready is ignored. Request fields may change freely while not ready.

Optional Feature:
MEM_ACCESS_STATS_EN
- When defined, the block adds three outputs, each 16 bits wide: stat_loads, stat_stores, stat_errs.
- Each counter increments in DONE for its access type. Errored requests count only in stat_errs.
- The counters saturate at 0xFFFF and are cleared by reset.
- When not defined, these ports and all counter logic are absent. Core behaviour is identical either way.

Test Plan:
1. sw 0x0000001F @4 -> Mem_WrEn=1 only in T+1 with ALU_MEM_Addr=4, MEM_DataIn=0x1F; resp_valid T+2, err=0. Then lw @4 -> resp_rdata=0x0000001F at T+3.
2. Preload word @8 = 0x11223344; sb wdata=0xAB @9 -> single write @8 of 0x1122AB44 at T+3, resp T+4. lb @9 -> 0xFFFFFFAB; lbu @9 -> 0x000000AB.
3. sh wdata=0x8001 @8 -> word @8 becomes 0x11228001. lh signed @8 -> 0xFFFF8001; lhu @10 -> 0x00001122.
4. Error cases, each giving resp_err=1 at T+1, resp_rdata=0, Mem_WrEn never high: lw @1; lh @3; size=11 @0; sw @4096 (word 1024).
5. Reset asserted during RD_WAIT of sb @9 -> no Mem_WrEn, no resp_valid, word @8 unchanged; req_ready=1 in the first cycle after reset drops.
6. req_valid held high with back-to-back lw @4 then lw @8 -> second accepted only on the edge after DONE; req_ready=0 in RD_ISSUE/RD_WAIT/DONE. With MEM_ACCESS_STATS_EN -> stat_loads=2.
